muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/mdu_compute.sv | 76 +++++++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encoding and default parameter values.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [OP_W-1:0] OP_MFHI  = 4'd7;
  localparam logic [OP_W-1:0] OP_MFLO  = 4'd8;
  localparam logic [OP_W-1:0] OP_MADD  = 4'd9;
  localparam logic [OP_W-1:0] OP_MADDU = 4'd10;
  localparam logic [OP_W-1:0] OP_MSUB  = 4'd11;
  localparam logic [OP_W-1:0] OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_compute.sv
// Combinational result generator: produces the full {hi,lo} pair an accepted
// op will eventually commit.
// Ports:
//   op           operation code
//   a, b         operands (rs, rt)
//   hi, lo       current HI/LO (accumulate base, divide-by-zero hold value)
//   res_hi/lo    resulting HI/LO
module mdu_compute
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int unsigned DW = 2 * WIDTH;

  logic             sgn_mul;
  logic [DW-1:0]    ext_a;
  logic [DW-1:0]    ext_b;
  logic [DW-1:0]    prod;
  logic [DW-1:0]    acc;
  logic             sgn_div;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Product: sign- or zero-extend to 2*WIDTH, keep the low 2*WIDTH bits
  always_comb begin
    sgn_mul = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    ext_a   = sgn_mul ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b   = sgn_mul ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod    = ext_a * ext_b;
    acc     = {hi, lo};
  end

  // Divide on magnitudes; avoids the most-negative/-1 overflow trap and
  // naturally yields quotient = most-negative, remainder = 0 for that case
  always_comb begin
    sgn_div = (op == OP_DIV);
    neg_a   = sgn_div & a[WIDTH-1];
    neg_b   = sgn_div & b[WIDTH-1];
    mag_a   = neg_a ? -a : a;
    mag_b   = neg_b ? -b : b;
    dvs     = (mag_b == '0) ? WIDTH'(1) : mag_b;
    q_mag   = mag_a / dvs;
    r_mag   = mag_a % dvs;
    quo     = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem     = neg_a ? -r_mag : r_mag;
  end

  // Result select; divide by zero returns the current HI/LO unchanged
  always_comb begin
    {res_hi, res_lo} = acc;
    case (op)
      OP_MULT, OP_MULTU: {res_hi, res_lo} = prod;
      OP_DIV, OP_DIVU:   if (b != '0) {res_hi, res_lo} = {rem, quo};
      OP_MADD, OP_MADDU: {res_hi, res_lo} = acc + prod;
      OP_MSUB, OP_MSUBU: {res_hi, res_lo} = acc - prod;
      default:           {res_hi, res_lo} = acc;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// An accepted MULT/DIV-class op computes its result immediately into pending
// registers; busy is then held for MULT_CYCLES/DIV_CYCLES and HI/LO commit
// on the last busy edge.
// Build option: define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU;
// otherwise those op codes are NOPs.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   op_valid     qualifies op/a/b
//   op           operation code
//   a, b         operands
//   int_req      blocks acceptance this cycle
//   start        combinational pulse on MULT/DIV-class accept
//   busy         registered, high while an op is in flight
//   res          combinational HI (MFHI) / LO (MFLO) / 0
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             int_req,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic [WIDTH-1:0] cmp_hi;
  logic [WIDTH-1:0] cmp_lo;
  logic             accept;
  logic             mul_op;
  logic             div_op;
  logic             commit;

  mdu_compute #(.WIDTH(WIDTH)) u_compute (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .res_hi (cmp_hi),
    .res_lo (cmp_lo)
  );

  // Op classification
  always_comb begin
    mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_MADD_EN
    mul_op = mul_op || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    div_op = (op == OP_DIV) || (op == OP_DIVU);
    accept = op_valid & ~int_req & ~reset & (state == ST_IDLE);
  end

  // Next-state, counter and start pulse
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && mul_op) begin
          state_nxt = ST_MUL;
          cnt_nxt   = CNT_W'(MULT_CYCLES - 1);
          start     = 1'b1;
        end else if (accept && div_op) begin
          state_nxt = ST_DIV;
          cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
          start     = 1'b1;
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  // Pending result and HI/LO; MTHI/MTLO write directly at accept
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      if (start) begin
        pend_hi <= cmp_hi;
        pend_lo <= cmp_lo;
      end
      if (commit) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end else if (accept && (op == OP_MTHI)) begin
        hi <= a;
      end else if (accept && (op == OP_MTLO)) begin
        lo <= a;
      end
    end
  end

  // Register read-out
  always_comb begin
    res = '0;
    if (op == OP_MFHI)      res = hi;
    else if (op == OP_MFLO) res = lo;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        int_req;
  logic        start;
  logic        busy;
  logic [31:0] res;

  int          n_chk;
  int          n_pass;
  logic [31:0] post_lo;

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .int_req  (int_req),
    .start    (start),
    .busy     (busy),
    .res      (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
  endtask

  // Issue one op in cycle 0 and follow it through n busy cycles to cycle n+1.
  // irq0: int_req with the op; irq_cyc: busy cycle with int_req high;
  // inj_cyc: busy cycle in which a DIVU is presented (must be ignored);
  // chain: issue in the current cycle instead of waiting for the next one.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n, input bit irq0,
                        input int irq_cyc, input int inj_cyc, input bit chain);
    if (!chain) @(negedge clk);
    op_valid = 1'b1; op = o; a = x; b = y; int_req = irq0;
    #1;
    check({tag, ":start"}, 32'(start), 32'(n > 0));
    check({tag, ":res0"}, res, 32'h0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      op_valid = (k == inj_cyc); op = OP_DIVU; a = 32'd1; b = 32'd1;
      int_req = (k == irq_cyc);
      #1;
      check({tag, ":busy"}, 32'(busy), 32'd1);
      if (k == inj_cyc) check({tag, ":ign_start"}, 32'(start), 32'd0);
    end
    @(negedge clk);
    op_valid = 1'b1; op = OP_MFLO; int_req = 1'b0;
    #1;
    check({tag, ":done"}, 32'(busy), 32'd0);
    post_lo = res;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    op_valid = 1'b1; op = OP_MFHI; int_req = 1'b0;
    #1;
    check({tag, ":hi"}, res, eh);
    @(negedge clk);
    op = OP_MFLO;
    #1;
    check({tag, ":lo"}, res, el);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; post_lo = '0;
    reset = 1'b1; op_valid = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3; int_req = 1'b0;

    // Reset: no start, not busy, HI/LO cleared
    @(negedge clk); #1;
    check("rst:start", 32'(start), 32'd0);
    @(negedge clk); #1;
    check("rst:busy", 32'(busy), 32'd0);
    op_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    read_hilo("rst", 32'h0, 32'h0);

    // Signed multiply -2*3
    run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, 0, 0, 0, 0);
    check("mult:lo_n1", post_lo, 32'hFFFF_FFFA);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // Signed divide -7/2, then divide by zero keeps HI/LO
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 0, 0, 0, 0);
    read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divz", OP_DIVU, 32'd7, 32'd0, 10, 0, 0, 0, 0);
    read_hilo("divz", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // int_req blocks accept; int_req while busy does not cancel
    run_op("irq0", OP_MULTU, 32'd5, 32'd5, 0, 1, 0, 0, 0);
    read_hilo("irq0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("irq3", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 3, 0, 0);
    read_hilo("irq3", 32'hFFFF_FFFE, 32'h0000_0001);

    // MTLO visible next cycle, MTHI
    run_op("mtlo", OP_MTLO, 32'h0000_1234, 32'd0, 0, 0, 0, 0, 0);
    check("mtlo:next", post_lo, 32'h0000_1234);
    run_op("mthi", OP_MTHI, 32'h0000_ABCD, 32'd0, 0, 0, 0, 0, 0);
    read_hilo("mthi", 32'h0000_ABCD, 32'h0000_1234);

    // DIVU in busy cycle 2 of a MULT is ignored (busy ends after 5)
    run_op("inj", OP_MULT, 32'd3, 32'd4, 5, 0, 0, 2, 0);
    read_hilo("inj", 32'h0, 32'd12);

    // Signed corner cases
    run_op("mneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 0, 0, 0);
    read_hilo("mneg", 32'h0, 32'h8000_0000);
    run_op("dneg", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, 0, 0, 0, 0);
    read_hilo("dneg", 32'd1, 32'hFFFF_FFFD);

    // Back-to-back accept in cycle N+1
    run_op("b2b1", OP_MULTU, 32'd5, 32'd6, 5, 0, 0, 0, 0);
    check("b2b1:lo", post_lo, 32'd30);
    run_op("b2b2", OP_DIVU, 32'd100, 32'd7, 10, 0, 0, 0, 1);
    read_hilo("b2b", 32'd2, 32'd14);

    // Reserved op code is a NOP
    run_op("nop13", 4'd13, 32'd9, 32'd9, 0, 0, 0, 0, 0);
    read_hilo("nop13", 32'd2, 32'd14);

    // Reset in cycle 3 of a DIV aborts it and clears HI/LO
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
    #1;
    check("rdiv:start", 32'(start), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      op_valid = 1'b0;
      if (k == 3) reset = 1'b1;
      #1;
      check("rdiv:busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0; op_valid = 1'b1; op = OP_MFHI;
    #1;
    check("rdiv:busy0", 32'(busy), 32'd0);
    check("rdiv:hi", res, 32'h0);
    @(negedge clk);
    op = OP_MFLO;
    #1;
    check("rdiv:lo", res, 32'h0);
    check("rdiv:idle", 32'(busy), 32'd0);

    // Accumulate ops: HI:LO = 0:5
    run_op("mtlo5", OP_MTLO, 32'd5, 32'd0, 0, 0, 0, 0, 0);
`ifdef MULDIV_MADD_EN
    run_op("madd", OP_MADD, 32'd2, 32'd2, 5, 0, 0, 0, 0);
    read_hilo("madd", 32'h0, 32'd9);
    run_op("msub", OP_MSUB, 32'd3, 32'd4, 5, 0, 0, 0, 0);
    read_hilo("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
    run_op("madd", OP_MADD, 32'd2, 32'd2, 0, 0, 0, 0, 0);
    read_hilo("madd", 32'h0, 32'd5);
    run_op("msubu", OP_MSUBU, 32'd3, 32'd4, 0, 0, 0, 0, 0);
    read_hilo("msubu", 32'h0, 32'd5);
`endif

    @(negedge clk);
    op_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
